grid_mem_arbiter: RTL and testbench

- Shares one single-port, synchronous-read grid memory (256 x 2-bit cells) between two requesters.
- Requester 1: the game controller, read/write, high priority. Requester 2: the display renderer, read-only, low priority.
- Priority is fixed, with an anti-starvation counter that forces a display grant when the display has waited too long.
- One instance sits in front of each board memory (own grid, enemy grid).

---
 rtl/grid_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_grid_mem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/grid_mem_arbiter.sv
// Arbitrates one synchronous-read grid memory between the game controller (read/write,
// high priority) and the display renderer (read-only, low priority, anti-starvation).
module grid_mem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  game_req,
    input  logic                  game_w_nr,
    input  logic [ADDR_WIDTH-1:0] game_addr,
    input  logic [DATA_WIDTH-1:0] game_wdata,
    output logic                  game_ack,
    output logic [DATA_WIDTH-1:0] game_rdata,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_ack,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_w_nr,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  busy
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("grid_mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        GAME_WR,
        RD_ISSUE,
        RD_DATA,
        ACK
    } state_t;

    state_t                r_state;
    logic                  r_win_disp;
    logic [3:0]            r_starve_cnt;
    logic                  r_game_ack;
    logic                  r_disp_ack;
    logic [DATA_WIDTH-1:0] r_game_rdata;
    logic [DATA_WIDTH-1:0] r_disp_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_w_nr;
    logic [DATA_WIDTH-1:0] r_mem_data_out;

    logic w_game_rq;
    logic w_disp_rq;
    logic w_disp_wins;
    logic w_game_wins;
    logic w_disp_active;

    // A requester whose ack is high this cycle is finishing, not asking again.
    assign w_game_rq     = game_req & ~r_game_ack;
    assign w_disp_rq     = disp_req & ~r_disp_ack;
    assign w_disp_wins   = w_disp_rq & (~w_game_rq | (r_starve_cnt == LP_LIMIT));
    assign w_game_wins   = w_game_rq & ~w_disp_wins;
    assign w_disp_active = (r_state != IDLE) & r_win_disp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_win_disp     <= 1'b0;
            r_game_ack     <= 1'b0;
            r_disp_ack     <= 1'b0;
            r_game_rdata   <= '0;
            r_disp_rdata   <= '0;
            r_mem_addr     <= '0;
            r_mem_w_nr     <= 1'b0;
            r_mem_data_out <= '0;
        end else begin
            // NOTE: acks default low every cycle so each one is a single-cycle pulse.
            r_game_ack <= 1'b0;
            r_disp_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_disp_wins) begin
                        r_mem_addr <= disp_addr;
                        r_mem_w_nr <= 1'b0;
                        r_win_disp <= 1'b1;
                        r_state    <= RD_ISSUE;
                    end else if (w_game_wins) begin
                        r_mem_addr <= game_addr;
                        r_win_disp <= 1'b0;
                        if (game_w_nr) begin
                            r_mem_data_out <= game_wdata;
                            r_mem_w_nr     <= 1'b1;
                            r_game_ack     <= 1'b1;
                            r_state        <= GAME_WR;
                        end else begin
                            r_mem_w_nr <= 1'b0;
                            r_state    <= RD_ISSUE;
                        end
                    end
                end
                GAME_WR: begin
                    r_mem_w_nr <= 1'b0;
                    r_state    <= IDLE;
                end
                RD_ISSUE: r_state <= RD_DATA;
                RD_DATA: begin
                    if (r_win_disp) begin
                        r_disp_rdata <= mem_data_in;
                        r_disp_ack   <= 1'b1;
                    end else begin
                        r_game_rdata <= mem_data_in;
                        r_game_ack   <= 1'b1;
                    end
                    r_state <= ACK;
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Counts cycles the display waits while someone else holds the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!disp_req || (r_state == IDLE && w_disp_wins)) begin
            r_starve_cnt <= '0;
        end else if (!w_disp_active && r_starve_cnt != LP_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign game_ack     = r_game_ack;
    assign game_rdata   = r_game_rdata;
    assign disp_ack     = r_disp_ack;
    assign disp_rdata   = r_disp_rdata;
    assign mem_addr     = r_mem_addr;
    assign mem_w_nr     = r_mem_w_nr;
    assign mem_data_out = r_mem_data_out;
    assign busy         = (r_state != IDLE);

    a_game_stable: assert property (@(posedge clk) disable iff (rst)
        (game_req && !game_ack) |=> (!game_req || $stable({game_w_nr, game_addr, game_wdata})));
    a_disp_stable: assert property (@(posedge clk) disable iff (rst)
        (disp_req && !disp_ack) |=> (!disp_req || $stable(disp_addr)));

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter with a behavioural synchronous-read grid memory.
module tb_grid_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_req, game_w_nr, disp_req;
    logic [7:0] game_addr, disp_addr, mem_addr;
    logic [1:0] game_wdata, game_rdata, disp_rdata, mem_data_out;
    logic [1:0] mem_data_in = 2'b00;
    logic       game_ack, disp_ack, mem_w_nr, busy;
    logic [1:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    grid_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .game_req(game_req), .game_w_nr(game_w_nr), .game_addr(game_addr),
        .game_wdata(game_wdata), .game_ack(game_ack), .game_rdata(game_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rdata(disp_rdata), .mem_addr(mem_addr), .mem_w_nr(mem_w_nr),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_w_nr) mem[mem_addr] <= mem_data_out;
        mem_data_in <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".game_ack"}, 32'(game_ack), 0);
        check({tag, ".disp_ack"}, 32'(disp_ack), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".mem_w_nr"}, 32'(mem_w_nr), 0);
        check({tag, ".mem_addr"}, 32'(mem_addr), 0);
        check({tag, ".mem_data_out"}, 32'(mem_data_out), 0);
        check({tag, ".game_rdata"}, 32'(game_rdata), 0);
        check({tag, ".disp_rdata"}, 32'(disp_rdata), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        game_req = 1'b0; game_w_nr = 1'b0; game_addr = 8'h00; game_wdata = 2'b00;
        disp_req = 1'b0; disp_addr = 8'h00;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Game write alone: 0x23 <= 01, ack and strobe in cycle 1 only.
        game_req = 1'b1; game_w_nr = 1'b1; game_addr = 8'h23; game_wdata = 2'b01;
        check("wr.c0.busy", 32'(busy), 0);
        tick();
        check("wr.c1.ack", 32'(game_ack), 1);
        check("wr.c1.w_nr", 32'(mem_w_nr), 1);
        check("wr.c1.addr", 32'(mem_addr), 32'h23);
        check("wr.c1.data", 32'(mem_data_out), 1);
        check("wr.c1.busy", 32'(busy), 1);
        game_req = 1'b0;
        tick();
        check("wr.c2.ack", 32'(game_ack), 0);
        check("wr.c2.w_nr", 32'(mem_w_nr), 0);
        check("wr.c2.busy", 32'(busy), 0);
        check("wr.c2.addr_hold", 32'(mem_addr), 32'h23);
        check("wr.c2.data_hold", 32'(mem_data_out), 1);

        // Game read-back of 0x23: ack 3 cycles later with 01.
        game_req = 1'b1; game_w_nr = 1'b0; game_addr = 8'h23;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("rd.c%0d.ack", c), 32'(game_ack), (c == 3) ? 1 : 0);
            check($sformatf("rd.c%0d.w_nr", c), 32'(mem_w_nr), 0);
            check($sformatf("rd.c%0d.busy", c), 32'(busy), 1);
        end
        check("rd.rdata", 32'(game_rdata), 1);
        game_req = 1'b0;
        tick();
        check("rd.c4.ack", 32'(game_ack), 0);
        check("rd.c4.busy", 32'(busy), 0);

        // Seed 0x99 with 11 for the display read.
        game_req = 1'b1; game_w_nr = 1'b1; game_addr = 8'h99; game_wdata = 2'b11;
        tick();
        check("seed.ack", 32'(game_ack), 1);
        game_req = 1'b0;
        tick();

        // Display read of 0x99: ack 3 cycles later with 11, game never acked.
        disp_req = 1'b1; disp_addr = 8'h99;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("disp.c%0d.ack", c), 32'(disp_ack), (c == 3) ? 1 : 0);
            check($sformatf("disp.c%0d.game_ack", c), 32'(game_ack), 0);
        end
        check("disp.rdata", 32'(disp_rdata), 3);
        check("disp.game_rdata_hold", 32'(game_rdata), 1);
        disp_req = 1'b0;
        tick();

        // Contention: game write 0x10 <= 10 and display read of 0x23 raised together.
        game_req = 1'b1; game_w_nr = 1'b1; game_addr = 8'h10; game_wdata = 2'b10;
        disp_req = 1'b1; disp_addr = 8'h23;
        tick();
        check("cont.c1.game_ack", 32'(game_ack), 1);
        check("cont.c1.disp_ack", 32'(disp_ack), 0);
        check("cont.c1.addr", 32'(mem_addr), 32'h10);
        game_req = 1'b0;
        tick();
        check("cont.c2.busy", 32'(busy), 0);
        tick();
        check("cont.c3.busy", 32'(busy), 1);
        check("cont.c3.addr", 32'(mem_addr), 32'h23);
        check("cont.c3.w_nr", 32'(mem_w_nr), 0);
        tick();
        check("cont.c4.disp_ack", 32'(disp_ack), 0);
        tick();
        check("cont.c5.disp_ack", 32'(disp_ack), 1);
        check("cont.c5.disp_rdata", 32'(disp_rdata), 1);
        disp_req = 1'b0;
        tick();

        // Starvation: game writes back-to-back, display granted when starve_cnt hits 4.
        game_req = 1'b1; game_w_nr = 1'b1; game_addr = 8'h50; game_wdata = 2'b11;
        disp_req = 1'b1; disp_addr = 8'h10;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check($sformatf("starve.c%0d.game_ack", c), 32'(game_ack),
                  (c == 1 || c == 3 || c == 9) ? 1 : 0);
            check($sformatf("starve.c%0d.disp_ack", c), 32'(disp_ack), (c == 7) ? 1 : 0);
            if (c == 5) check("starve.c5.addr", 32'(mem_addr), 32'h10);
            if (c == 7) begin
                check("starve.c7.disp_rdata", 32'(disp_rdata), 2);
                disp_req = 1'b0;
            end
        end
        game_req = 1'b0;
        tick();

        // Reset asserted during RD_DATA of a game read of 0x50.
        game_req = 1'b1; game_w_nr = 1'b0; game_addr = 8'h50;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        game_req = 1'b0;
        tick();
        tick();
        check("rst_mid.no_ack", 32'(game_ack), 0);
        rst = 1'b0;

        // After reset: write 0x40 <= 10 completes in one cycle, then read it back.
        game_req = 1'b1; game_w_nr = 1'b1; game_addr = 8'h40; game_wdata = 2'b10;
        tick();
        check("post.c1.ack", 32'(game_ack), 1);
        check("post.c1.w_nr", 32'(mem_w_nr), 1);
        check("post.c1.addr", 32'(mem_addr), 32'h40);
        check("post.c1.data", 32'(mem_data_out), 2);
        game_req = 1'b0;
        tick();
        check("post.c2.busy", 32'(busy), 0);
        game_req = 1'b1; game_w_nr = 1'b0;
        tick();
        tick();
        tick();
        check("post.rd.ack", 32'(game_ack), 1);
        check("post.rd.rdata", 32'(game_rdata), 2);
        game_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
